adc_capture: RTL and testbench

ADC_CAPTURE -- requirements
Module: adc_capture

---
 rtl/adc_capture.sv | 138 +++++++++++++
 tb/tb_adc_capture.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture.sv
// Dual-channel 12-bit serial ADC capture with a shared sclk/cs_n and a periodic sample tick.
// Optional leading-zero frame check is built when ADC_FRAME_CHECK_EN is defined.
module adc_capture #(
    parameter int CLKDIV    = 4,
    parameter int SAMPLEDIV = 250
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        miso1,
    input  logic        miso2,
    output logic        sclk,
    output logic        cs_n,
    output logic [11:0] rx1,
    output logic [11:0] rx2,
    output logic        endata,
    output logic        overrun,
    output logic        frameerr
);

    localparam int CW = $clog2(SAMPLEDIV);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [7:0]    div;
    logic [4:0]    half;
    logic [15:0]   sh1;
    logic [15:0]   sh2;
    logic          tick;
    logic          div_end;
    logic          done;
    logic          frame_ok;

    assign tick    = enable && (cnt == CW'(SAMPLEDIV - 1));
    assign div_end = (div == 8'(CLKDIV - 1));
    assign done    = (state == HOLD) && div_end;

    // sclk is low in even half-periods of SHIFT, so SHIFT opens with a falling edge
    assign cs_n = (state == IDLE);
    assign sclk = (state == SHIFT) ? half[0] : 1'b1;

`ifdef ADC_FRAME_CHECK_EN
    assign frame_ok = (sh1[15:12] == 4'd0) && (sh2[15:12] == 4'd0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frameerr <= 1'b0;
        end else begin
            frameerr <= (frameerr && enable) || (done && !frame_ok);
        end
    end
`else
    logic unused_lead;

    assign frame_ok    = 1'b1;
    assign frameerr    = 1'b0;
    assign unused_lead = ^{sh1[15:12], sh2[15:12]};
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (tick) state_nx = SETUP;
            SETUP: if (div_end) state_nx = SHIFT;
            SHIFT: if (div_end && half == 5'd31) state_nx = HOLD;
            HOLD:  if (div_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            div  <= '0;
            half <= '0;
        end else begin
            if (!enable || cnt == CW'(SAMPLEDIV - 1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (state == IDLE || div_end) begin
                div <= '0;
            end else begin
                div <= div + 1'b1;
            end
            if (state != SHIFT) begin
                half <= '0;
            end else if (div_end) begin
                half <= half + 1'b1;
            end
        end
    end

    // Sample on the first cycle of each sclk-high half-period
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sh1 <= '0;
            sh2 <= '0;
        end else if (state == SHIFT && half[0] && div == 8'd0) begin
            sh1 <= {sh1[14:0], miso1};
            sh2 <= {sh2[14:0], miso2};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx1     <= '0;
            rx2     <= '0;
            endata  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            endata  <= done && frame_ok;
            overrun <= enable && (overrun || (tick && state != IDLE));
            if (done && frame_ok) begin
                rx1 <= sh1[11:0];
                rx2 <= sh2[11:0];
            end
        end
    end

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture: latency, framing, hold, overrun, enable drop,
// mid-frame reset and the ADC_FRAME_CHECK_EN leading-bit check.
module tb_adc_capture;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        miso1;
    logic        miso2;
    logic        sclk;
    logic        cs_n;
    logic [11:0] rx1;
    logic [11:0] rx2;
    logic        endata;
    logic        overrun;
    logic        frameerr;

    logic        enable_f;
    logic        sclk_f;
    logic        cs_n_f;
    logic [11:0] rx1_f;
    logic [11:0] rx2_f;
    logic        endata_f;
    logic        overrun_f;
    logic        frameerr_f;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [15:0] w1;
    logic [15:0] w2;
    int  bidx = -1;
    logic prev_cs = 1'b1;
    logic prev_sclk = 1'b1;
    int  falls = 0;
    int  rises = 0;
    int  last_falls = 0;
    int  last_rises = 0;
    logic sclk_at_fall = 1'b0;
    logic sclk_at_rise = 1'b0;
    int  cs_falls = 0;
    int  cs_fall_cyc = 0;
    int  strobes = 0;
    int  strobe_cyc = 0;

    adc_capture #(.CLKDIV(4), .SAMPLEDIV(250)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .miso1(miso1), .miso2(miso2), .sclk(sclk), .cs_n(cs_n),
        .rx1(rx1), .rx2(rx2), .endata(endata),
        .overrun(overrun), .frameerr(frameerr)
    );

    adc_capture #(.CLKDIV(4), .SAMPLEDIV(100)) dut_fast (
        .clock(clock), .reset(reset), .enable(enable_f),
        .miso1(1'b0), .miso2(1'b0), .sclk(sclk_f), .cs_n(cs_n_f),
        .rx1(rx1_f), .rx2(rx2_f), .endata(endata_f),
        .overrun(overrun_f), .frameerr(frameerr_f)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // ADC model and bus monitor, evaluated mid-cycle when DUT outputs are settled
    always @(negedge clock) begin
        if (!cs_n && prev_cs) begin
            cs_falls++;
            cs_fall_cyc = cyc;
            sclk_at_fall = sclk;
            falls = 0;
            rises = 0;
        end
        if (!cs_n && !prev_cs) begin
            if (prev_sclk && !sclk) falls++;
            if (!prev_sclk && sclk) rises++;
        end
        if (cs_n && !prev_cs) begin
            last_falls = falls;
            last_rises = rises;
            sclk_at_rise = sclk;
        end
        if (cs_n) bidx = -1;
        else if (prev_sclk && !sclk) bidx++;
        miso1 = (bidx >= 0 && bidx < 16) ? w1[15 - bidx] : 1'b0;
        miso2 = (bidx >= 0 && bidx < 16) ? w2[15 - bidx] : 1'b0;
        if (endata) begin
            strobes++;
            strobe_cyc = cyc;
        end
        prev_cs = cs_n;
        prev_sclk = sclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic wait_cs(input int lim);
        int s;
        int i;
        s = cs_falls;
        i = 0;
        while (cs_falls == s && i < lim) begin
            step(1);
            i++;
        end
        chk("cs_fall_seen", 32'(cs_falls != s), 32'd1);
    endtask

    task automatic wait_strobe(input int lim);
        int s;
        int i;
        s = strobes;
        i = 0;
        while (strobes == s && i < lim) begin
            step(1);
            i++;
        end
        chk("strobe_seen", 32'(strobes != s), 32'd1);
    endtask

    initial begin
        int c;
        int s0;
        int prev_strobe;
        reset = 1'b0;
        enable = 1'b0;
        enable_f = 1'b0;
        w1 = 16'h0ABC;
        w2 = 16'h0123;
        step(3);
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd1);
        chk("rst_rx1", 32'(rx1), 32'd0);
        chk("rst_rx2", 32'(rx2), 32'd0);
        chk("rst_endata", 32'(endata), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_frameerr", 32'(frameerr), 32'd0);
        reset = 1'b1;
        step(2);

        // Overrun on the fast instance: tick 2 lands while frame 1 is busy
        c = cyc;
        enable_f = 1'b1;
        step(150);
        chk("ovr_after_tick1", 32'(overrun_f), 32'd0);
        step(55);
        chk("ovr_after_tick2", 32'(overrun_f), 32'd1);
        enable_f = 1'b0;
        step(1);
        chk("ovr_cleared", 32'(overrun_f), 32'd0);
        step(200);

        // Nominal sampling
        c = cyc;
        enable = 1'b1;
        wait_cs(300);
        chk("cs_fall_delay", 32'(cs_fall_cyc - c), 32'd250);
        wait_strobe(200);
        chk("endata_latency", 32'(strobe_cyc - cs_fall_cyc), 32'd136);
        chk("rx1_abc", 32'(rx1), 32'h0ABC);
        chk("rx2_123", 32'(rx2), 32'h0123);
        chk("sclk_at_cs_fall", 32'(sclk_at_fall), 32'd1);
        chk("sclk_at_cs_rise", 32'(sclk_at_rise), 32'd1);
        chk("sclk_falls", 32'(last_falls), 32'd16);
        chk("sclk_rises", 32'(last_rises), 32'd16);
        chk("cs_high_at_strobe", 32'(cs_n), 32'd1);
        step(1);
        chk("endata_one_cycle", 32'(endata), 32'd0);
        prev_strobe = strobe_cyc;
        w1 = 16'h0555;
        step(10);
        chk("rx1_hold", 32'(rx1), 32'h0ABC);
        wait_strobe(300);
        chk("strobe_period", 32'(strobe_cyc - prev_strobe), 32'd250);
        chk("rx1_555", 32'(rx1), 32'h0555);
        chk("overrun_clean", 32'(overrun), 32'd0);

        // Enable dropped in SHIFT cycle 20: frame still completes
        wait_cs(300);
        step(24);
        enable = 1'b0;
        wait_strobe(200);
        chk("drop_latency", 32'(strobe_cyc - cs_fall_cyc), 32'd136);
        chk("drop_rx1", 32'(rx1), 32'h0555);
        s0 = cs_falls;
        step(600);
        chk("drop_no_cs", 32'(cs_falls), 32'(s0));

        // Leading bit set on channel 2
        w1 = 16'h0ABC;
        w2 = 16'h8123;
        enable = 1'b1;
        wait_cs(300);
        s0 = strobes;
        step(140);
`ifdef ADC_FRAME_CHECK_EN
        chk("fc_no_strobe", 32'(strobes), 32'(s0));
        chk("fc_frameerr", 32'(frameerr), 32'd1);
        chk("fc_rx1_kept", 32'(rx1), 32'h0555);
        chk("fc_rx2_kept", 32'(rx2), 32'h0123);
        enable = 1'b0;
        step(2);
        chk("fc_err_cleared", 32'(frameerr), 32'd0);
`else
        chk("fc_strobe", 32'(strobes), 32'(s0 + 1));
        chk("fc_frameerr", 32'(frameerr), 32'd0);
        chk("fc_rx1", 32'(rx1), 32'h0ABC);
        chk("fc_rx2", 32'(rx2), 32'h0123);
        enable = 1'b0;
        step(2);
`endif
        w2 = 16'h0123;

        // Reset in the middle of SHIFT
        enable = 1'b1;
        wait_cs(300);
        step(30);
        reset = 1'b0;
        #1;
        chk("mid_rst_cs_n", 32'(cs_n), 32'd1);
        chk("mid_rst_sclk", 32'(sclk), 32'd1);
        chk("mid_rst_rx1", 32'(rx1), 32'd0);
        chk("mid_rst_rx2", 32'(rx2), 32'd0);
        step(3);
        s0 = strobes;
        reset = 1'b1;
        step(150);
        chk("mid_rst_no_strobe", 32'(strobes), 32'(s0));
        wait_strobe(600);
        chk("resume_rx1", 32'(rx1), 32'h0ABC);
        chk("resume_rx2", 32'(rx2), 32'h0123);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
